// File: rtl/c2c_mem_responder.sv
// Single-port word RAM behind the c2c read/write channels. One access in
// flight, round-robin arbitration on contention, programmable wait states.
module c2c_mem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r_req,
  input  logic [XLEN-1:0]   r_addr,
  output logic              r_ack,
  output logic [XLEN-1:0]   r_data,
  output logic              r_err,
  input  logic              w_req,
  input  logic [XLEN-1:0]   w_addr,
  input  logic [XLEN-1:0]   w_data,
  input  logic [XLEN/8-1:0] w_sel,
  output logic              w_ack,
  output logic              w_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {CH_READ, CH_WRITE} chan_t;

  state_t state, state_nxt;
  chan_t grant, grant_nxt, last_grant, last_grant_nxt, cur;
  logic [3:0] cnt, cnt_nxt;
  logic commit;
  logic cur_req;

  logic [XLEN-1:0] mem [DEPTH];

  logic [AW-1:0] r_idx, w_idx;
  logic r_oor, w_oor;
  logic unused_lsbs;

  assign r_idx = r_addr[AW+1:2];
  assign w_idx = w_addr[AW+1:2];
  assign r_oor = |r_addr[XLEN-1:AW+2];
  assign w_oor = |w_addr[XLEN-1:AW+2];
  assign unused_lsbs = ^{r_addr[1:0], w_addr[1:0]};

  assign cur_req = (grant == CH_READ) ? r_req : w_req;

  // In IDLE the channel chosen this cycle is used directly so that a
  // single-cycle latency can commit on the very edge that grants it.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    commit         = 1'b0;
    cur            = grant;
    case (state)
      IDLE: begin
        if (r_req || w_req) begin
          if (r_req && w_req)
            cur = (last_grant == CH_READ) ? CH_WRITE : CH_READ;
          else
            cur = r_req ? CH_READ : CH_WRITE;
          grant_nxt      = cur;
          last_grant_nxt = cur;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!cur_req)
          state_nxt = IDLE;
        else if (cnt != 4'd0)
          cnt_nxt = cnt - 4'd1;
        else begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= CH_READ;
      last_grant <= CH_WRITE;
      cnt        <= 4'd0;
      r_data     <= '0;
      r_err      <= 1'b0;
      w_err      <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      if (commit) begin
        if (cur == CH_READ) begin
          r_data <= r_oor ? '0 : mem[r_idx];
          r_err  <= r_oor;
        end else begin
          w_err  <= w_oor;
        end
      end
    end
  end

  // RAM contents survive reset, so the array lives in its own clocked block.
  always_ff @(posedge clk) begin
    if (commit && cur == CH_WRITE && !w_oor) begin
      for (int i = 0; i < NB; i++) begin
        if (w_sel[i])
          mem[w_idx][i*8 +: 8] <= w_data[i*8 +: 8];
      end
    end
  end

  assign r_ack = (state == RESP) && (grant == CH_READ);
  assign w_ack = (state == RESP) && (grant == CH_WRITE);

endmodule

// File: tb/tb_c2c_mem_responder.sv
// Directed bench for c2c_mem_responder: instance 0 runs LATENCY=1,
// instance 1 runs LATENCY=4; both share clock and reset.
module tb_c2c_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  r_req, w_req;
  logic [31:0] r_addr [2];
  logic [31:0] w_addr [2];
  logic [31:0] w_data [2];
  logic [3:0]  w_sel  [2];
  logic [1:0]  r_ack, w_ack, r_err, w_err;
  logic [31:0] r_data [2];

  int checks = 0;
  int errors = 0;
  int both_ack_cnt = 0;

  always #5 clk = ~clk;

  c2c_mem_responder #(.XLEN(32), .DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .r_req(r_req[0]), .r_addr(r_addr[0]), .r_ack(r_ack[0]), .r_data(r_data[0]), .r_err(r_err[0]),
    .w_req(w_req[0]), .w_addr(w_addr[0]), .w_data(w_data[0]), .w_sel(w_sel[0]),
    .w_ack(w_ack[0]), .w_err(w_err[0])
  );

  c2c_mem_responder #(.XLEN(32), .DEPTH(1024), .LATENCY(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .r_req(r_req[1]), .r_addr(r_addr[1]), .r_ack(r_ack[1]), .r_data(r_data[1]), .r_err(r_err[1]),
    .w_req(w_req[1]), .w_addr(w_addr[1]), .w_data(w_data[1]), .w_sel(w_sel[1]),
    .w_ack(w_ack[1]), .w_err(w_err[1])
  );

  always @(negedge clk) begin
    if ((r_ack[0] && w_ack[0]) || (r_ack[1] && w_ack[1]))
      both_ack_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on instance d; lat = cycles from req to ack, -1 on timeout.
  task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] sel,
                               output int lat, output logic [31:0] rd, output logic err);
    lat = -1;
    rd  = '0;
    err = 1'b0;
    if (wr) begin
      w_addr[d] = addr; w_data[d] = data; w_sel[d] = sel; w_req[d] = 1'b1;
    end else begin
      r_addr[d] = addr; r_req[d] = 1'b1;
    end
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      step();
      if (wr && w_ack[d]) begin
        lat = c; err = w_err[d];
      end else if (!wr && r_ack[d]) begin
        lat = c; rd = r_data[d]; err = r_err[d];
      end
    end
    if (wr) w_req[d] = 1'b0;
    else    r_req[d] = 1'b0;
    step();
  endtask

  // Both channels raised together on instance 1; returns ack cycles.
  task automatic runPair(input logic [31:0] raddr, input logic [31:0] waddr, input logic [31:0] wdata,
                         output int rc, output int wc, output logic [31:0] rd);
    rc = -1; wc = -1; rd = '0;
    r_addr[1] = raddr; w_addr[1] = waddr; w_data[1] = wdata; w_sel[1] = 4'hF;
    r_req[1] = 1'b1; w_req[1] = 1'b1;
    for (int c = 1; c <= 40 && (rc < 0 || wc < 0); c++) begin
      step();
      if (r_ack[1]) begin rc = c; rd = r_data[1]; r_req[1] = 1'b0; end
      if (w_ack[1]) begin wc = c; w_req[1] = 1'b0; end
    end
    r_req[1] = 1'b0; w_req[1] = 1'b0;
    step();
  endtask

  int lat, rc, wc, acks, ack_c0, ack_c1;
  logic [31:0] rd, d0, d1;
  logic err;

  initial begin
    reset_n = 1'b0;
    r_req = '0; w_req = '0;
    for (int i = 0; i < 2; i++) begin
      r_addr[i] = '0; w_addr[i] = '0; w_data[i] = '0; w_sel[i] = '0;
    end
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset flags d%0d", i), {28'd0, r_ack[i], w_ack[i], r_err[i], w_err[i]}, 32'd0);
      checkOutput($sformatf("reset r_data d%0d", i), r_data[i], 32'd0);
    end
    step();

    // LATENCY=1 basic write/read
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, err);
    checkOutput("l1 write lat", 32'(lat), 32'd1);
    checkOutput("l1 write err", {31'd0, err}, 32'd0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, err);
    checkOutput("l1 read lat", 32'(lat), 32'd1);
    checkOutput("l1 read data", rd, 32'hDEADBEEF);
    checkOutput("l1 read err", {31'd0, err}, 32'd0);

    // byte strobes
    applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, err);
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, lat, rd, err);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, err);
    checkOutput("strobe 0x5 data", rd, 32'h11BB33DD);
    applyStimulus(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, lat, rd, err);
    checkOutput("sel0 write lat", 32'(lat), 32'd1);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, err);
    checkOutput("sel0 unchanged", rd, 32'h11BB33DD);

    // LATENCY=4 contention
    applyStimulus(1, 1'b1, 32'h40, 32'h12345678, 4'hF, lat, rd, err);
    checkOutput("l4 write lat", 32'(lat), 32'd4);
    runPair(32'h40, 32'h44, 32'hCAFEF00D, rc, wc, rd);
    checkOutput("pair1 r cycle", 32'(rc), 32'd4);
    checkOutput("pair1 w cycle", 32'(wc), 32'd9);
    checkOutput("pair1 r data", rd, 32'h12345678);
    applyStimulus(1, 1'b0, 32'h44, 32'h0, 4'h0, lat, rd, err);
    checkOutput("l4 read lat", 32'(lat), 32'd4);
    checkOutput("l4 read data", rd, 32'hCAFEF00D);
    runPair(32'h40, 32'h40, 32'h0BADF00D, rc, wc, rd);
    checkOutput("pair2 w cycle", 32'(wc), 32'd4);
    checkOutput("pair2 r cycle", 32'(rc), 32'd9);
    checkOutput("pair2 r data", rd, 32'h0BADF00D);

    // abort: write dropped at cycle 2
    applyStimulus(1, 1'b1, 32'h30, 32'h55AA55AA, 4'hF, lat, rd, err);
    w_addr[1] = 32'h30; w_data[1] = 32'hFFFFFFFF; w_sel[1] = 4'hF; w_req[1] = 1'b1;
    acks = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (w_ack[1]) acks++;
      if (c == 2) w_req[1] = 1'b0;
    end
    checkOutput("abort no ack", 32'(acks), 32'd0);
    applyStimulus(1, 1'b0, 32'h30, 32'h0, 4'h0, lat, rd, err);
    checkOutput("abort old value", rd, 32'h55AA55AA);

    // out of range
    applyStimulus(1, 1'b1, 32'h0, 32'h600DF00D, 4'hF, lat, rd, err);
    applyStimulus(1, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, err);
    checkOutput("oor read lat", 32'(lat), 32'd4);
    checkOutput("oor read err", {31'd0, err}, 32'd1);
    checkOutput("oor read data", rd, 32'd0);
    applyStimulus(1, 1'b1, 32'h1000, 32'h99999999, 4'hF, lat, rd, err);
    checkOutput("oor write err", {31'd0, err}, 32'd1);

    // back-to-back reads with req held
    applyStimulus(1, 1'b1, 32'h4, 32'h44444444, 4'hF, lat, rd, err);
    r_addr[1] = 32'h0; r_req[1] = 1'b1;
    acks = 0; ack_c0 = -1; ack_c1 = -1; d0 = '0; d1 = '0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (r_ack[1]) begin
        acks++;
        if (acks == 1) begin ack_c0 = c; d0 = r_data[1]; r_addr[1] = 32'h4; end
        else if (acks == 2) begin ack_c1 = c; d1 = r_data[1]; r_req[1] = 1'b0; end
      end
    end
    r_req[1] = 1'b0;
    checkOutput("b2b ack count", 32'(acks), 32'd2);
    checkOutput("b2b first cycle", 32'(ack_c0), 32'd4);
    checkOutput("b2b second cycle", 32'(ack_c1), 32'd9);
    checkOutput("b2b data 0x0", d0, 32'h600DF00D);
    checkOutput("b2b data 0x4", d1, 32'h44444444);

    // reset during WAIT
    r_addr[1] = 32'h4; r_req[1] = 1'b1;
    acks = 0;
    step(); step();
    reset_n = 1'b0;
    r_req[1] = 1'b0;
    step();
    reset_n = 1'b1;
    checkOutput("post-reset flags", {28'd0, r_ack[1], w_ack[1], r_err[1], w_err[1]}, 32'd0);
    checkOutput("post-reset r_data", r_data[1], 32'd0);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (r_ack[1]) acks++;
    end
    checkOutput("reset drop no ack", 32'(acks), 32'd0);
    runPair(32'h4, 32'h8, 32'h88888888, rc, wc, rd);
    checkOutput("reset pair r cycle", 32'(rc), 32'd4);
    checkOutput("reset pair w cycle", 32'(wc), 32'd9);
    checkOutput("reset pair r data", rd, 32'h44444444);

    checkOutput("never both acks", 32'(both_ack_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
